// File: rtl/cci_test_flow_ctrl_pkg.sv
// Shared types and width helper for the per-channel request-line flow limiter.
package cci_test_flow_ctrl_pkg;

    typedef logic [2:0] t_req_lines;

    typedef enum logic {
        OPEN      = 1'b0,
        THROTTLED = 1'b1
    } t_flow_state;

    // Counter must hold MAX_ACTIVE_LINES itself, hence the extra bit.
    function automatic int calc_cnt_w(input int max_lines);
        return $clog2(max_lines) + 1;
    endfunction

endpackage

// File: rtl/cci_test_flow_ctrl_chan.sv
// One channel: saturating outstanding-line counter, OPEN/THROTTLED hysteresis FSM,
// optional statistics when CCI_TEST_FLOW_CTRL_STATS_EN is defined.
module cci_test_flow_ctrl_chan
    import cci_test_flow_ctrl_pkg::*;
#(
    parameter int MAX_ACTIVE_LINES = 512,
    parameter int HEADROOM         = 8,
    parameter int HYST             = 16,
    localparam int CNT_W           = calc_cnt_w(MAX_ACTIVE_LINES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] limit,
    input  logic             req_valid,
    input  t_req_lines       req_lines,
    input  logic             rsp_valid,
    input  t_req_lines       rsp_lines,
    input  logic             fiu_alm_full,
    output logic             afu_alm_full,
    output logic [CNT_W-1:0] active_lines,
    output logic             cnt_err
`ifdef CCI_TEST_FLOW_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] peak_lines,
    output logic [31:0]      throttle_cycles
`endif
);

    localparam int EXT_W = CNT_W + 2;
    localparam logic signed [EXT_W-1:0] MAX_S  = EXT_W'(MAX_ACTIVE_LINES);
    localparam logic signed [EXT_W-1:0] HEAD_S = EXT_W'(HEADROOM);
    localparam logic signed [EXT_W-1:0] HYST_S = EXT_W'(HYST);

    t_flow_state             state_r;
    t_flow_state             state_next_s;
    logic [CNT_W-1:0]        active_r;
    logic [CNT_W-1:0]        next_cnt_s;
    logic                    cnt_err_r;
    logic                    err_next_s;
    logic                    illegal_s;
    logic signed [EXT_W-1:0] req_s;
    logic signed [EXT_W-1:0] rsp_s;
    logic signed [EXT_W-1:0] sum_s;
    logic signed [EXT_W-1:0] next_ext_s;
    logic signed [EXT_W-1:0] limit_s;

    assign req_s   = req_valid ? signed'(EXT_W'(req_lines)) : '0;
    assign rsp_s   = rsp_valid ? signed'(EXT_W'(rsp_lines)) : '0;
    assign sum_s   = signed'({2'b00, active_r}) + req_s - rsp_s;
    assign limit_s = signed'({2'b00, limit});

    // Zero or more than four lines is a protocol error; the raw value still counts.
    assign illegal_s = (req_valid && (req_lines == 3'd0 || req_lines > 3'd4)) ||
                       (rsp_valid && (rsp_lines == 3'd0 || rsp_lines > 3'd4));

    // Clamp the next count into [0, MAX_ACTIVE_LINES] and accumulate the sticky error.
    always_comb begin
        next_cnt_s = sum_s[CNT_W-1:0];
        err_next_s = cnt_err_r | illegal_s;
        if (sum_s[EXT_W-1]) begin
            next_cnt_s = '0;
            err_next_s = 1'b1;
        end else if (sum_s > MAX_S) begin
            next_cnt_s = MAX_S[CNT_W-1:0];
            err_next_s = 1'b1;
        end else begin
            next_cnt_s = sum_s[CNT_W-1:0];
        end
    end

    assign next_ext_s = signed'({2'b00, next_cnt_s});

    // Throttle decision against the clamped next count and this cycle's limit.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            OPEN: begin
                if (limit != '0 && (next_ext_s + HEAD_S) >= limit_s) begin
                    state_next_s = THROTTLED;
                end else begin
                    state_next_s = OPEN;
                end
            end
            THROTTLED: begin
                if (limit == '0 || (next_ext_s + HEAD_S + HYST_S) < limit_s) begin
                    state_next_s = OPEN;
                end else begin
                    state_next_s = THROTTLED;
                end
            end
            default: state_next_s = OPEN;
        endcase
    end

    // Counter, FSM state and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_r  <= '0;
            state_r   <= OPEN;
            cnt_err_r <= 1'b0;
        end else begin
            active_r  <= next_cnt_s;
            state_r   <= state_next_s;
            cnt_err_r <= err_next_s;
        end
    end

    assign afu_alm_full = fiu_alm_full | (state_r == THROTTLED);
    assign active_lines = active_r;
    assign cnt_err      = cnt_err_r;

`ifdef CCI_TEST_FLOW_CTRL_STATS_EN
    logic [CNT_W-1:0] peak_r;
    logic [31:0]      thr_cnt_r;

    // Peak tracks the value being loaded so it never lags active_lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_r    <= '0;
            thr_cnt_r <= 32'd0;
        end else begin
            if (next_cnt_s > peak_r) begin
                peak_r <= next_cnt_s;
            end else begin
                peak_r <= peak_r;
            end
            if (state_r == THROTTLED && thr_cnt_r != 32'hFFFF_FFFF) begin
                thr_cnt_r <= thr_cnt_r + 32'd1;
            end else begin
                thr_cnt_r <= thr_cnt_r;
            end
        end
    end

    assign peak_lines      = peak_r;
    assign throttle_cycles = thr_cnt_r;
`endif

endmodule

// File: rtl/cci_test_flow_ctrl.sv
// Per-channel flow limiter top: one cci_test_flow_ctrl_chan per channel.
// Optional statistics ports are enabled by defining CCI_TEST_FLOW_CTRL_STATS_EN.
module cci_test_flow_ctrl
    import cci_test_flow_ctrl_pkg::*;
#(
    parameter int NUM_CHANNELS     = 2,
    parameter int MAX_ACTIVE_LINES = 512,
    parameter int HEADROOM         = 8,
    parameter int HYST             = 16,
    localparam int CNT_W           = calc_cnt_w(MAX_ACTIVE_LINES)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CHANNELS-1:0][CNT_W-1:0]  limit,
    input  logic [NUM_CHANNELS-1:0]             req_valid,
    input  logic [NUM_CHANNELS-1:0][2:0]        req_lines,
    input  logic [NUM_CHANNELS-1:0]             rsp_valid,
    input  logic [NUM_CHANNELS-1:0][2:0]        rsp_lines,
    input  logic [NUM_CHANNELS-1:0]             fiu_alm_full,
    output logic [NUM_CHANNELS-1:0]             afu_alm_full,
    output logic [NUM_CHANNELS-1:0][CNT_W-1:0]  active_lines,
    output logic [NUM_CHANNELS-1:0]             cnt_err
`ifdef CCI_TEST_FLOW_CTRL_STATS_EN
    ,
    output logic [NUM_CHANNELS-1:0][CNT_W-1:0]  peak_lines,
    output logic [NUM_CHANNELS-1:0][31:0]       throttle_cycles
`endif
);

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
        cci_test_flow_ctrl_chan #(
            .MAX_ACTIVE_LINES (MAX_ACTIVE_LINES),
            .HEADROOM         (HEADROOM),
            .HYST             (HYST)
        ) u_chan (
            .clk             (clk),
            .reset           (reset),
            .limit           (limit[ch]),
            .req_valid       (req_valid[ch]),
            .req_lines       (req_lines[ch]),
            .rsp_valid       (rsp_valid[ch]),
            .rsp_lines       (rsp_lines[ch]),
            .fiu_alm_full    (fiu_alm_full[ch]),
            .afu_alm_full    (afu_alm_full[ch]),
            .active_lines    (active_lines[ch]),
            .cnt_err         (cnt_err[ch])
`ifdef CCI_TEST_FLOW_CTRL_STATS_EN
            ,
            .peak_lines      (peak_lines[ch]),
            .throttle_cycles (throttle_cycles[ch])
`endif
        );
    end

endmodule

// File: tb/tb_cci_test_flow_ctrl.sv
// Scoreboard bench for cci_test_flow_ctrl: directed vectors push expected state,
// a monitor pops and compares after every clock edge.
module tb_cci_test_flow_ctrl;

    localparam int CNT_W = 10;

    typedef struct {
        logic [9:0]  a0;
        logic [9:0]  a1;
        logic [1:0]  af;
        logic [1:0]  er;
        logic        chk_stats;
        logic [9:0]  pk0;
        logic [31:0] tc0;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [1:0][CNT_W-1:0] limit;
    logic [1:0]            req_valid;
    logic [1:0][2:0]       req_lines;
    logic [1:0]            rsp_valid;
    logic [1:0][2:0]       rsp_lines;
    logic [1:0]            fiu_alm_full;
    logic [1:0]            afu_alm_full;
    logic [1:0][CNT_W-1:0] active_lines;
    logic [1:0]            cnt_err;
`ifdef CCI_TEST_FLOW_CTRL_STATS_EN
    logic [1:0][CNT_W-1:0] peak_lines;
    logic [1:0][31:0]      throttle_cycles;
`endif

    exp_t sb[$];
    exp_t mon_e;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc_no    = 0;
    logic        st_chk = 1'b0;
    logic [9:0]  st_pk  = 10'd0;
    logic [31:0] st_tc  = 32'd0;

    always #5 clk = ~clk;

    cci_test_flow_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .limit           (limit),
        .req_valid       (req_valid),
        .req_lines       (req_lines),
        .rsp_valid       (rsp_valid),
        .rsp_lines       (rsp_lines),
        .fiu_alm_full    (fiu_alm_full),
        .afu_alm_full    (afu_alm_full),
        .active_lines    (active_lines),
        .cnt_err         (cnt_err)
`ifdef CCI_TEST_FLOW_CTRL_STATS_EN
        ,
        .peak_lines      (peak_lines),
        .throttle_cycles (throttle_cycles)
`endif
    );

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc_no, got, exp);
        end
    endfunction

    // Monitor: compare DUT outputs against the oldest expectation after each edge.
    always @(posedge clk) begin
        #1;
        cyc_no++;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("active_lines0", 32'(active_lines[0]), 32'(mon_e.a0));
            check("active_lines1", 32'(active_lines[1]), 32'(mon_e.a1));
            check("afu_alm_full",  32'(afu_alm_full),    32'(mon_e.af));
            check("cnt_err",       32'(cnt_err),         32'(mon_e.er));
`ifdef CCI_TEST_FLOW_CTRL_STATS_EN
            if (mon_e.chk_stats) begin
                check("peak_lines0",      32'(peak_lines[0]),  32'(mon_e.pk0));
                check("throttle_cycles0", throttle_cycles[0],  mon_e.tc0);
            end
`endif
        end
    end

    task automatic cyc(input logic [9:0] a0, input logic [9:0] a1,
                       input logic [1:0] af, input logic [1:0] er);
        exp_t e;
        e.a0 = a0; e.a1 = a1; e.af = af; e.er = er;
        e.chk_stats = st_chk; e.pk0 = st_pk; e.tc0 = st_tc;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 2'b00; rsp_valid = 2'b00;
        req_lines = '0;    rsp_lines = '0;
    endtask

    task automatic req(input int ch, input logic [2:0] n);
        req_valid[ch] = 1'b1; req_lines[ch] = n;
    endtask

    task automatic rsp(input int ch, input logic [2:0] n);
        rsp_valid[ch] = 1'b1; rsp_lines[ch] = n;
    endtask

    initial begin
        reset = 1'b1; limit[0] = 10'd32; limit[1] = 10'd32; fiu_alm_full = 2'b00; idle();
        cyc(10'd0, 10'd0, 2'b00, 2'b00);
        cyc(10'd0, 10'd0, 2'b00, 2'b00);
        reset = 1'b0;

        // Six 4-line requests: throttle once 24 + 8 reaches 32.
        for (int k = 1; k <= 6; k++) begin
            idle(); req(0, 3'd4);
            cyc(10'(4 * k), 10'd0, (k == 6) ? 2'b01 : 2'b00, 2'b00);
        end
        // Retire one line per cycle: release only at 7 (7+8+16 < 32).
        for (int k = 23; k >= 7; k--) begin
            idle(); rsp(0, 3'd1);
            cyc(10'(k), 10'd0, (k == 7) ? 2'b00 : 2'b01, 2'b00);
        end
        idle(); req(0, 3'd3);
        cyc(10'd10, 10'd0, 2'b00, 2'b00);
        // Balanced req/rsp holds the count; fiu almost-full passes straight through.
        fiu_alm_full = 2'b10;
        for (int k = 0; k < 4; k++) begin
            idle(); req(0, 3'd4); rsp(0, 3'd4);
            cyc(10'd10, 10'd0, 2'b10, 2'b00);
        end
        fiu_alm_full = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            idle(); req(0, 3'd4);
            cyc(10'(10 + 4 * k), 10'd0, (k >= 4) ? 2'b01 : 2'b00, 2'b00);
        end
        // limit=0 releases throttle the next cycle.
        idle(); limit[0] = 10'd0; fiu_alm_full = 2'b01;
        cyc(10'd30, 10'd0, 2'b01, 2'b00);
        fiu_alm_full = 2'b00;
        cyc(10'd30, 10'd0, 2'b00, 2'b00);
        req(0, 3'd4);
        cyc(10'd34, 10'd0, 2'b00, 2'b00);

        // Mid-run reset, then in-flight responses underflow.
        idle(); limit[0] = 10'd32; reset = 1'b1;
        cyc(10'd0, 10'd0, 2'b00, 2'b00);
        reset = 1'b0; rsp(1, 3'd2);
        cyc(10'd0, 10'd0, 2'b00, 2'b10);
        idle(); req(0, 3'd1);
        cyc(10'd1, 10'd0, 2'b00, 2'b10);
        idle(); rsp(0, 3'd2);
        cyc(10'd0, 10'd0, 2'b00, 2'b11);
        idle();
        cyc(10'd0, 10'd0, 2'b00, 2'b11);

        // Limit below headroom throttles with zero lines; illegal line counts.
        limit[0] = 10'd5; reset = 1'b1;
        cyc(10'd0, 10'd0, 2'b00, 2'b00);
        reset = 1'b0;
        cyc(10'd0, 10'd0, 2'b01, 2'b00);
        req(1, 3'd5);
        cyc(10'd0, 10'd5, 2'b01, 2'b10);
        idle(); req(0, 3'd0);
        cyc(10'd0, 10'd5, 2'b01, 2'b11);

        // Saturation at MAX_ACTIVE_LINES on channel 1.
        idle(); limit[0] = 10'd32; limit[1] = 10'd0; reset = 1'b1;
        cyc(10'd0, 10'd0, 2'b00, 2'b00);
        reset = 1'b0;
        for (int k = 1; k <= 129; k++) begin
            idle(); req(1, 3'd4);
            cyc(10'd0, (k > 128) ? 10'd512 : 10'(4 * k), 2'b00, (k > 128) ? 2'b10 : 2'b00);
        end
        idle(); rsp(1, 3'd4);
        cyc(10'd0, 10'd508, 2'b00, 2'b10);

`ifdef CCI_TEST_FLOW_CTRL_STATS_EN
        idle(); limit[1] = 10'd32; reset = 1'b1; st_chk = 1'b1; st_pk = 10'd0; st_tc = 32'd0;
        cyc(10'd0, 10'd0, 2'b00, 2'b00);
        reset = 1'b0; st_chk = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            idle(); req(0, 3'd4);
            cyc(10'(4 * k), 10'd0, (k == 6) ? 2'b01 : 2'b00, 2'b00);
        end
        idle(); req(0, 3'd4);
        cyc(10'd28, 10'd0, 2'b01, 2'b00);
        idle(); req(0, 3'd2);
        cyc(10'd30, 10'd0, 2'b01, 2'b00);
        idle();
        for (int k = 1; k <= 18; k++) begin
            st_chk = (k == 18); st_pk = 10'd30; st_tc = 32'd20;
            cyc(10'd30, 10'd0, 2'b01, 2'b00);
        end
        reset = 1'b1; st_chk = 1'b1; st_pk = 10'd0; st_tc = 32'd0;
        cyc(10'd0, 10'd0, 2'b00, 2'b00);
        reset = 1'b0; st_chk = 1'b0;
`endif

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
